// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N stream demultiplexer with broadcast.
//
// One upstream valid/ready stream is steered to one of N downstream
// channels (SEL), or to all channels (BCAST=1). Each channel owns a
// one-entry output register, so a stalled consumer never loses data.
// Words addressed to SEL >= N are consumed, dropped and flagged on ERR.
//
// Ports:
//   CLK        rising-edge clock
//   N_RESET    asynchronous active-low reset
//   D          input word (W bits)
//   SEL        target channel index ($clog2(N) bits)
//   BCAST      1 = deliver to every channel, SEL ignored
//   VALID_IN   upstream word valid
//   READY_OUT  upstream may transfer this cycle (combinational)
//   Y          channel c data at Y[c*W +: W], 0 while the slot is empty
//   VALID_OUT  channel c holds a word
//   READY_IN   channel c consumer accepts this cycle
//   ERR        sticky: a word to an out-of-range channel was dropped

// One output slot: {vld, y}. A load always wins over a drain, so a slot
// emptied this cycle can be refilled in the same cycle without a bubble.
module demux_slot #(
   parameter int W = 1
) (
   input  logic         CLK,
   input  logic         N_RESET,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         rdy,
   output logic         vld,
   output logic [W-1:0] y
);
   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         vld <= 1'b0;
         y   <= '0;
      end else if (load) begin
         vld <= 1'b1;
         y   <= d;
      end else if (vld && rdy) begin
         vld <= 1'b0;
         y   <= '0;
      end
   end
endmodule

module demux_stream #(
   parameter int N = 8,
   parameter int W = 1
) (
   input  logic                 CLK,
   input  logic                 N_RESET,
   input  logic [W-1:0]         D,
   input  logic [$clog2(N)-1:0] SEL,
   input  logic                 BCAST,
   input  logic                 VALID_IN,
   output logic                 READY_OUT,
   output logic [N*W-1:0]       Y,
   output logic [N-1:0]         VALID_OUT,
   input  logic [N-1:0]         READY_IN,
   output logic                 ERR
);
   localparam int SW = $clog2(N);

   logic [N-1:0] free;
   logic [N-1:0] hit;
   logic [N-1:0] load;
   logic         sel_ok;
   logic         sel_free;
   logic         accept;
   logic         err_set;

   // One-hot decode of SEL. An all-zero result means SEL >= N; decoding
   // this way avoids an out-of-range index when N is not a power of two.
   always_comb begin
      hit = '0;
      for (int c = 0; c < N; c++) hit[c] = (SEL == SW'(c));
   end

   assign free     = ~VALID_OUT | READY_IN;
   assign sel_ok   = |hit;
   assign sel_free = |(hit & free);

   // Independent of VALID_IN, so no combinational path back upstream.
   // Bad selects are always taken so the stream never locks up.
   always_comb begin
      READY_OUT = 1'b1;
      if (BCAST)       READY_OUT = &free;
      else if (sel_ok) READY_OUT = sel_free;
   end

   assign accept  = VALID_IN & READY_OUT;
   assign load    = accept ? (BCAST ? {N{1'b1}} : hit) : '0;
   assign err_set = accept & ~BCAST & ~sel_ok;

   generate
      for (genvar c = 0; c < N; c++) begin : g_slot
         demux_slot #(.W(W)) u_slot (
            .CLK     (CLK),
            .N_RESET (N_RESET),
            .load    (load[c]),
            .d       (D),
            .rdy     (READY_IN[c]),
            .vld     (VALID_OUT[c]),
            .y       (Y[c*W +: W])
         );
      end
   endgenerate

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET)     ERR <= 1'b0;
      else if (err_set) ERR <= 1'b1;
   end
endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: N=8/W=8 instance with a per-channel queue
// scoreboard, plus an N=6 instance for out-of-range selects.
module tb_demux_stream;
   localparam int N  = 8;
   localparam int W  = 8;
   localparam int SW = 3;

   logic           CLK = 1'b0;
   logic           N_RESET = 1'b0;
   logic [W-1:0]   D = '0;
   logic [SW-1:0]  SEL = '0;
   logic           BCAST = 1'b0;
   logic           VALID_IN = 1'b0;
   logic           READY_OUT;
   logic [N*W-1:0] Y;
   logic [N-1:0]   VALID_OUT;
   logic [N-1:0]   READY_IN = '0;
   logic           ERR;

   logic [W-1:0]   d6 = '0;
   logic [2:0]     sel6 = '0;
   logic           bcast6 = 1'b0;
   logic           valid6 = 1'b0;
   logic           ready6;
   logic [6*W-1:0] y6;
   logic [5:0]     vout6;
   logic [5:0]     rin6 = '0;
   logic           err6;

   demux_stream #(.N(N), .W(W)) dut (
      .CLK(CLK), .N_RESET(N_RESET), .D(D), .SEL(SEL), .BCAST(BCAST),
      .VALID_IN(VALID_IN), .READY_OUT(READY_OUT), .Y(Y),
      .VALID_OUT(VALID_OUT), .READY_IN(READY_IN), .ERR(ERR)
   );

   demux_stream #(.N(6), .W(W)) dut6 (
      .CLK(CLK), .N_RESET(N_RESET), .D(d6), .SEL(sel6), .BCAST(bcast6),
      .VALID_IN(valid6), .READY_OUT(ready6), .Y(y6),
      .VALID_OUT(vout6), .READY_IN(rin6), .ERR(err6)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: each channel is a FIFO of words owed to its consumer.
   logic [W-1:0] q [N][$];
   logic         model_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // A channel can take a word if nothing is owed, or its one owed word
   // is being taken by the consumer this cycle.
   function automatic bit model_ready(bit bc, int s, logic [N-1:0] rin);
      bit all_free = 1'b1;
      for (int c = 0; c < N; c++)
         if (q[c].size() != 0 && !rin[c]) all_free = 1'b0;
      if (bc) return all_free;
      if (s < N) return (q[s].size() == 0) || rin[s];
      return 1'b1;
   endfunction

   // Stimulus side of the scoreboard: record what each accepted word owes.
   always @(posedge CLK) begin
      if (N_RESET && VALID_IN && model_ready(BCAST, int'(SEL), READY_IN)) begin
         if (BCAST) for (int c = 0; c < N; c++) q[c].push_back(D);
         else if (int'(SEL) < N) q[SEL].push_back(D);
         else model_err <= 1'b1;
      end
   end

   always @(negedge N_RESET) begin
      for (int c = 0; c < N; c++) q[c].delete();
      model_err <= 1'b0;
   end

   // Monitor: compare presented outputs against what is owed; retire a word
   // whenever the DUT hands one to a ready consumer.
   always @(negedge CLK) begin
      chk("ready_out", {63'd0, READY_OUT}, {63'd0, model_ready(BCAST, int'(SEL), READY_IN)});
      chk("err", {63'd0, ERR}, {63'd0, model_err});
      for (int c = 0; c < N; c++) begin
         if (VALID_OUT[c]) begin
            if (q[c].size() == 0) begin
               chk($sformatf("spurious_valid%0d", c), 64'd1, 64'd0);
            end else begin
               chk($sformatf("y%0d", c), {56'd0, Y[c*W +: W]}, {56'd0, q[c][0]});
               if (READY_IN[c]) void'(q[c].pop_front());
            end
         end else begin
            chk($sformatf("owed%0d", c), 64'(q[c].size()), 64'd0);
            chk($sformatf("empty_y%0d", c), {56'd0, Y[c*W +: W]}, 64'd0);
         end
      end
   end

   task automatic drive(input bit v, input bit bc, input int s, input logic [W-1:0] d);
      VALID_IN = v; BCAST = bc; SEL = s[SW-1:0]; D = d;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   initial begin
      // Reset held with traffic on the input.
      drive(1, 0, 0, 8'hFF);
      READY_IN = '0;
      repeat (3) tick();
      chk("rst_valid", 64'(VALID_OUT), 64'd0);
      chk("rst_y", Y, 64'd0);
      chk("rst_err", {63'd0, ERR}, 64'd0);
      chk("rst_err6", {63'd0, err6}, 64'd0);
      N_RESET = 1'b1;
      drive(0, 0, 3, 8'h00);
      #1 chk("rel_ready", {63'd0, READY_OUT}, 64'd1);
      tick();

      // Unicast sweep.
      READY_IN = '1;
      for (int n = 0; n < N; n++) begin
         drive(1, 0, n, 8'hA0 + W'(n));
         tick();
         chk($sformatf("sweep_valid%0d", n), 64'(VALID_OUT), 64'(1) << n);
         chk($sformatf("sweep_y%0d", n), Y, 64'(8'hA0 + n) << (8 * n));
      end
      drive(0, 0, 0, 0);
      tick();

      // Backpressure on channel 2.
      READY_IN = '0;
      drive(1, 0, 2, 8'h11);
      tick();
      chk("bp_valid", 64'(VALID_OUT), 64'h04);
      drive(1, 0, 2, 8'h22);
      #1 chk("bp_stall_ready", {63'd0, READY_OUT}, 64'd0);
      tick();
      chk("bp_hold_y", {56'd0, Y[2*W +: W]}, 64'h11);
      READY_IN = 8'h04;
      #1 chk("bp_release_ready", {63'd0, READY_OUT}, 64'd1);
      tick();
      drive(0, 0, 0, 0);
      chk("bp_new_y", {56'd0, Y[2*W +: W]}, 64'h22);
      chk("bp_new_valid", 64'(VALID_OUT), 64'h04);
      READY_IN = '1;
      tick();

      // Broadcast, then broadcast blocked by a full slot 7.
      drive(1, 1, 0, 8'h5A);
      tick();
      drive(0, 0, 0, 0);
      chk("bc_valid", 64'(VALID_OUT), 64'hFF);
      chk("bc_y", Y, {8{8'h5A}});
      READY_IN = 8'h7F;
      drive(1, 1, 0, 8'hC3);
      #1 chk("bc_block_ready", {63'd0, READY_OUT}, 64'd0);
      tick();
      chk("bc_block_valid", 64'(VALID_OUT), 64'h80);
      chk("bc_block_y7", {56'd0, Y[7*W +: W]}, 64'h5A);
      READY_IN = '1;
      tick();
      drive(0, 0, 0, 0);
      chk("bc2_y", Y, {8{8'hC3}});
      tick();

      // Asynchronous reset between edges while slots 2 and 5 stall.
      READY_IN = '0;
      drive(1, 0, 2, 8'h33);
      tick();
      drive(1, 0, 5, 8'h55);
      tick();
      drive(0, 0, 0, 0);
      chk("stall_valid", 64'(VALID_OUT), 64'h24);
      #1 N_RESET = 1'b0;
      #1 chk("arst_valid", 64'(VALID_OUT), 64'd0);
      chk("arst_y", Y, 64'd0);
      #1 N_RESET = 1'b1;
      tick();

      // Random traffic against the scoreboard.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, N - 1)), W'($urandom));
         READY_IN = N'($urandom) | N'($urandom);
         tick();
      end
      drive(0, 0, 0, 0);
      READY_IN = '1;
      tick();

      // Out-of-range select on the N=6 build.
      rin6 = '0;
      sel6 = 3'd7; d6 = 8'h99; valid6 = 1'b1;
      #1 chk("bad_ready6", {63'd0, ready6}, 64'd1);
      chk("bad_err6_pre", {63'd0, err6}, 64'd0);
      tick();
      chk("bad_valid6", 64'(vout6), 64'd0);
      chk("bad_err6", {63'd0, err6}, 64'd1);
      sel6 = 3'd1; d6 = 8'h77;
      tick();
      chk("good_valid6", 64'(vout6), 64'h02);
      chk("good_y6", y6, 64'h77 << 8);
      chk("err6_sticky", {63'd0, err6}, 64'd1);
      sel6 = 3'd6; d6 = 8'h66;
      #1 chk("bad6_ready6", {63'd0, ready6}, 64'd1);
      tick();
      valid6 = 1'b0;
      chk("bad6_valid6", 64'(vout6), 64'h02);
      chk("err6_sticky2", {63'd0, err6}, 64'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
